// File: rtl/if_queue_pkg.sv
// Shared types and helpers for the IF/ID fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_queue_pkg;

    // Default field width and the instruction driven while the queue is empty.
    localparam int          IFQ_DATA_W   = 32;
    localparam logic [31:0] IFQ_NOP_INST = 32'h0000_0000;

    // One queue entry at the default width: {pc, instruction}.
    typedef struct packed {
        logic [IFQ_DATA_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] instruction;
    } if_entry_t;

    // Pointer width for a power-of-two depth.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/if_queue_ptr.sv
// Wrap-around pointer with increment enable and synchronous clear.
// Latency: new value visible one edge after i_inc / i_clr.
// Backpressure: none; the caller decides when to increment.
//
// Ports: clk, rst (async, active-high), i_clr (sync clear, wins over i_inc),
//        i_inc (advance by one, wraps modulo 2**W), o_ptr (current value).
module if_queue_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            // Power-of-two depth, so the natural overflow is the wrap.
            r_ptr <= r_ptr + W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/if_fetch_queue.sv
// DEPTH-entry FIFO of {pc, instruction} between fetch and decode.
// Latency: 1 edge from push to head on an empty queue (0 with IF_QUEUE_BYPASS_EN).
// Backpressure: full blocks pushes unless the head pops that cycle; freeze holds the head.
//
// Ports: clk, rst (async, active-high); flush, freeze, push, pc_in, instruction_in
//        from fetch/decode control; full, count, valid, pc, instruction to decode.
// Optional: define IF_QUEUE_BYPASS_EN to forward a push straight to the outputs
//           when the queue is empty.
module if_fetch_queue
    import if_queue_pkg::*;
#(
    parameter int                DATA_W   = IFQ_DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(IFQ_NOP_INST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       freeze,
    input  logic                       push,
    input  logic [DATA_W-1:0]          pc_in,
    input  logic [DATA_W-1:0]          instruction_in,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       valid,
    output logic [DATA_W-1:0]          pc,
    output logic [DATA_W-1:0]          instruction
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instruction;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [CNT_W-1:0]   r_count;

    logic [PTR_W-1:0]   w_wr_ptr;
    logic [PTR_W-1:0]   w_rd_ptr;
    logic               w_stored;   // at least one entry held in storage
    logic               w_full;
    logic               w_pop;
    logic               w_accept;
    logic               w_byp;      // input forwarded to the outputs this cycle
    logic               w_byp_take; // forwarded entry consumed, so never stored
    entry_t             w_head;

    assign w_stored = (r_count != '0);
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_head   = r_mem[w_rd_ptr];

    // Pop only consumes stored entries; a bypassed entry is handled separately.
    assign w_pop = w_stored & ~freeze & ~flush;

`ifdef IF_QUEUE_BYPASS_EN
    assign w_byp      = ~w_stored & push & ~flush;
    assign w_byp_take = w_byp & ~freeze;
`else
    assign w_byp      = 1'b0;
    assign w_byp_take = 1'b0;
`endif

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_accept = push & ~flush & (~w_full | w_pop) & ~w_byp_take;

    if_queue_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_accept),
        .o_ptr (w_wr_ptr)
    );

    if_queue_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
        end
    end

    // Storage is deliberately left unreset; outputs mask it while empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[w_wr_ptr] <= '{pc: pc_in, instruction: instruction_in};
        end
    end

    always_comb begin
        pc          = '0;
        instruction = NOP_INST;
        if (w_stored) begin
            pc          = w_head.pc;
            instruction = w_head.instruction;
        end else if (w_byp) begin
            pc          = pc_in;
            instruction = instruction_in;
        end
    end

    assign valid = w_stored | w_byp;
    assign full  = w_full;
    assign count = r_count;

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, instruction} pairs between the fetch stage and decode.
- Decouples fetch from decode stalls: fetch keeps pushing while decode is frozen, until the queue is full.
- Keeps the freeze/flush semantics of the IF/ID register, adds valid, full and occupancy outputs, and adds wrap-around storage.

Parameters:
- DATA_W, 32, width of pc and instruction fields.
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INST, 32'h0000_0000, instruction value driven when the queue is empty (width DATA_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discard all entries (branch taken / redirect).
- freeze  input  1  decode stall; head is not consumed this cycle.
- push  input  1  fetch offers pc_in/instruction_in this cycle.
- pc_in  input  DATA_W  fetched PC+4 value.
- instruction_in  input  DATA_W  fetched instruction.
- full  output  1  count == DEPTH.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- valid  output  1  head entry present.
- pc  output  DATA_W  head pc; 0 when empty.
- instruction  output  DATA_W  head instruction; NOP_INST when empty.

Behaviour:
- State:
  - entry array[DEPTH];
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, incrementing modulo DEPTH and wrapping naturally;
  - count register.
- pop = valid & ~freeze & ~flush. The head advances at the next edge.
- accept = push & ~flush & (~full | pop):
  - write at wr_ptr;
  - wr_ptr+1.
- Push while full and not popping:
  - ignored, no state change;
  - fetch must hold its PC (fetch freezes on full).
- Push and pop in the same cycle:
  - count unchanged, both pointers advance;
  - legal when full and when count == 1 (with count == 1 the new entry becomes head next cycle).
- count next = count + accept - pop; never exceeds DEPTH, never underflows.
- Outputs are combinational from registered state:
  - valid = (count != 0);
  - pc/instruction = entry[rd_ptr] when valid, else 0 / NOP_INST.
  - Storage contents are never visible while empty.
- Latency: an entry pushed at edge N appears at the head after edge N if the queue was empty, otherwise after all older entries pop.
- flush has the highest priority:
  - at the next edge count=0, wr_ptr=rd_ptr=0;
  - a simultaneous push is discarded;
  - freeze is ignored during flush.
- Freeze with an empty queue: no effect on the pop side; pushes are still accepted.
- Reset (asynchronous, any time, including mid-burst):
  - count=0, pointers=0, so valid=0, pc=0, instruction=NOP_INST, full=0;
  - entry storage is not cleared.
  - The first edge after rst deasserts behaves normally.

Optional Feature:
- Macro IF_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and push & ~flush, outputs show pc_in/instruction_in combinationally with valid=1.
  - If ~freeze in that cycle, the entry is consumed immediately and not stored (count stays 0).
  - If freeze, it is stored normally.
  - Zero-latency path for the empty queue.
- Not defined:
  - No combinational path from inputs to outputs;
  - minimum latency 1 cycle, as described above.

Decomposition:
- Shared package if_queue_pkg:
  - typedef if_entry_t (packed {pc, instruction});
  - constant NOP_INST default value;
  - localparam helper for pointer width ($clog2(DEPTH)).
- One natural sub-module, if_queue_ptr: a wrap-around pointer with increment enable and synchronous clear (flush), asynchronous reset. It is instantiated twice, for rd_ptr and wr_ptr.

Test Plan:
- Reset, then push pc=0x4/inst=0x1111, 0x8/0x2222, 0xC/0x3333 with freeze=0 -> valid rises one cycle after the first push; outputs show 0x4, 0x8, 0xC in order; count returns to 0; instruction then = NOP_INST.
- freeze=1, push 5 entries with DEPTH=4 -> full=1 and count=4 after 4 pushes; the 5th (pc=0x14) is ignored; release freeze -> heads 0x4..0x10, no 0x14.
- Full queue, push and pop in the same cycle for 6 cycles -> count stays 4, FIFO order preserved across pointer wrap.
- count=3, flush=1 together with push=1 -> next cycle count=0, valid=0, pc=0; the pushed entry never appears.
- Assert rst asynchronously mid-cycle with count=2 -> valid, full and count are 0 immediately, before the next edge; after release, a push is seen at the head one cycle later.
- With IF_QUEUE_BYPASS_EN and an empty queue, push pc=0x40 with freeze=0 -> valid=1 and pc=0x40 in the same cycle, count stays 0; repeated with freeze=1 -> count=1 next cycle.
